// File: rtl/uart_wb_master.sv
// uart_wb_master: Wishbone classic master that polls a UART register window.
// Each poll reads the UCR status word and then, if needed, either drains one
// received byte into a valid/ready stream or writes one byte from two
// round-robin arbitrated transmit requesters. All outputs are registered.
module uart_wb_master #(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        tx0_valid,
  input  logic [7:0]  tx0_data,
  output logic        tx0_ready,
  input  logic        tx1_valid,
  input  logic [7:0]  tx1_data,
  output logic        tx1_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        rx_err,
  output logic        bus_err
);

  localparam logic [31:0] DATA_ADR = BASE_ADR + 32'd4;
  // GAP leaves once the counter has stepped through 0..POLL_GAP.
  localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP);
  // cyc stays high for exactly ACK_TIMEOUT cycles when no ack arrives.
  localparam logic [7:0]  TO_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {GAP, POLL, RD_DATA, WR_DATA} state_t;

  state_t     state;
  logic [7:0] gap_cnt;
  logic [7:0] to_cnt;
  logic       cyc;
  logic       last_grant;   // 1 = tx1 was granted last
  logic       grant;        // requester owning the pending write
  logic       any_tx;
  logic       grant_pick;
  logic       unused_dat;

  // cyc and stb are the same register, so they can never disagree.
  assign wb_cyc_o   = cyc;
  assign wb_stb_o   = cyc;
  assign wb_sel_o   = 4'hF;
  assign unused_dat = ^wb_dat_i[31:8];

  // Round-robin choice evaluated at the poll ack: a tie goes to the requester
  // that did not win last time, a single requester always wins.
  always_comb begin
    any_tx = tx0_valid | tx1_valid;
    if (tx0_valid && tx1_valid) begin
      grant_pick = ~last_grant;
    end else begin
      grant_pick = tx1_valid;
    end
  end

  // Sequencer: idle gap, poll/read/write bus cycles, ack timeout and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= GAP;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      cyc        <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      tx0_ready  <= 1'b0;
      tx1_ready  <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_err     <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      tx0_ready <= 1'b0;
      tx1_ready <= 1'b0;
      rx_err    <= 1'b0;
      bus_err   <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (cyc && !wb_ack_i) begin
        // Waiting on the slave; abandon the cycle once the budget is spent.
        if (to_cnt == TO_LAST) begin
          cyc     <= 1'b0;
          wb_we_o <= 1'b0;
          bus_err <= 1'b1;
          state   <= GAP;
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
      end else begin
        case (state)
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt  <= '0;
              to_cnt   <= '0;
              cyc      <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_adr_o <= BASE_ADR;
              state    <= POLL;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end

          POLL: begin
            // Only reachable here with cyc high and ack present.
            cyc    <= 1'b0;
            rx_err <= wb_dat_i[1];
            if (wb_dat_i[0] && !rx_valid) begin
              state <= RD_DATA;
            end else if (!wb_dat_i[4] && any_tx) begin
              state    <= WR_DATA;
              grant    <= grant_pick;
              wb_dat_o <= {24'h0, grant_pick ? tx1_data : tx0_data};
            end else begin
              state <= GAP;
            end
          end

          RD_DATA: begin
            if (!cyc) begin
              to_cnt   <= '0;
              cyc      <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_adr_o <= DATA_ADR;
            end else begin
              cyc      <= 1'b0;
              rx_data  <= wb_dat_i[7:0];
              rx_valid <= 1'b1;
              state    <= GAP;
            end
          end

          WR_DATA: begin
            if (!cyc) begin
              to_cnt   <= '0;
              cyc      <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_adr_o <= DATA_ADR;
            end else begin
              cyc        <= 1'b0;
              wb_we_o    <= 1'b0;
              last_grant <= grant;
              if (grant) begin
                tx1_ready <= 1'b1;
              end else begin
                tx0_ready <= 1'b1;
              end
              state <= GAP;
            end
          end

          default: state <= GAP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: randomized bench with a transaction-level model of the
// poll/read/write protocol, a reactive Wishbone slave and two requesters.
module tb_uart_wb_master;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int          GAP  = 4;
  localparam int          TMO  = 8;
  localparam int OP_POLL = 0;
  localparam int OP_RD   = 1;
  localparam int OP_WR   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        tx0_valid = 1'b0, tx1_valid = 1'b0;
  logic [7:0]  tx0_data = '0, tx1_data = '0;
  logic        tx0_ready, tx1_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic        rx_err, bus_err;

  always #5 clk = ~clk;

  uart_wb_master #(
    .BASE_ADR(BASE),
    .POLL_GAP(GAP),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .tx0_valid(tx0_valid), .tx0_data(tx0_data), .tx0_ready(tx0_ready),
    .tx1_valid(tx1_valid), .tx1_data(tx1_data), .tx1_ready(tx1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_err(rx_err), .bus_err(bus_err)
  );

  int checks = 0;
  int failures = 0;

  // transaction-level model
  int        next_op, cur_op, grant, last_grant;
  int        exp_low, low_cnt, hi_cnt, wait_left, txn_cnt = 0;
  logic [7:0] wr_byte, m_rx_byte;
  bit        m_rx_valid;
  bit        e_tx0r, e_tx1r, e_rxerr, e_buserr, e_drop, prev_cyc;

  // stimulus knobs
  bit          force_ucr_en = 1'b0;
  logic [31:0] force_ucr = '0;
  bit          req_always = 1'b0;
  bit          rx_ready_off = 1'b0;
  bit          slave_dead = 1'b0;
  bit          stall_wr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string op_name(input int op);
    if (op == OP_RD) return "READ";
    if (op == OP_WR) return "WRITE";
    return "POLL";
  endfunction

  task automatic model_init();
    next_op    = OP_POLL;
    cur_op     = OP_POLL;
    grant      = 0;
    last_grant = 1;
    exp_low    = GAP;
    low_cnt    = 0;
    hi_cnt     = 0;
    wait_left  = 0;
    m_rx_valid = 1'b0;
    m_rx_byte  = '0;
    wr_byte    = '0;
    e_tx0r = 0; e_tx1r = 0; e_rxerr = 0; e_buserr = 0; e_drop = 0;
    prev_cyc   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_cyc"}, wb_cyc_o, 0);
    check_eq({pfx, "_stb"}, wb_stb_o, 0);
    check_eq({pfx, "_we"}, wb_we_o, 0);
    check_eq({pfx, "_adr"}, wb_adr_o, 0);
    check_eq({pfx, "_dat"}, wb_dat_o, 0);
    check_eq({pfx, "_sel"}, wb_sel_o, 4'hF);
    check_eq({pfx, "_ready"}, {tx1_ready, tx0_ready}, 0);
    check_eq({pfx, "_rx_valid"}, rx_valid, 0);
    check_eq({pfx, "_errs"}, {rx_err, bus_err}, 0);
  endtask

  task automatic do_reset();
    wb_ack_i = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    model_init();
  endtask

  // One clock: check DUT against the model, then drive the next inputs and
  // derive what the model expects to see one clock later.
  task automatic step();
    bit          cyc_s, old_drop, tx0_done, tx1_done, rx_next;
    logic [31:0] ucr, junk;
    logic [7:0]  b;
    @(negedge clk);
    cyc_s = wb_cyc_o;
    check_eq("tx0_ready", tx0_ready, e_tx0r);
    check_eq("tx1_ready", tx1_ready, e_tx1r);
    check_eq("rx_err", rx_err, e_rxerr);
    check_eq("bus_err", bus_err, e_buserr);
    check_eq("rx_valid", rx_valid, m_rx_valid);
    if (m_rx_valid) check_eq("rx_data", rx_data, m_rx_byte);
    check_eq("stb_eq_cyc", wb_stb_o, wb_cyc_o);
    if (prev_cyc) check_eq("cyc_hold", cyc_s, !e_drop);
    else if (low_cnt >= exp_low) check_eq("cyc_rise", cyc_s, 1);
    else check_eq("cyc_idle", cyc_s, 0);

    if (!prev_cyc && cyc_s) begin
      cur_op    = next_op;
      hi_cnt    = 0;
      wait_left = $urandom_range(0, 3);
      check_eq("txn_we", wb_we_o, cur_op == OP_WR);
      check_eq("txn_adr", wb_adr_o, (cur_op == OP_POLL) ? BASE : BASE + 32'd4);
      check_eq("txn_sel", wb_sel_o, 4'hF);
      if (cur_op == OP_WR) check_eq("txn_wdat", wb_dat_o, {24'h0, wr_byte});
    end
    if (cyc_s) begin
      hi_cnt++;
      low_cnt = 0;
    end else begin
      low_cnt = prev_cyc ? 1 : low_cnt + 1;
    end
    prev_cyc = cyc_s;

    old_drop = e_drop;
    tx0_done = e_tx0r;
    tx1_done = e_tx1r;
    e_tx0r = 0; e_tx1r = 0; e_rxerr = 0; e_buserr = 0; e_drop = 0;

    // requesters hold a byte until it is consumed
    if (tx0_done) begin
      tx0_valid = req_always | ($urandom_range(0, 1) == 1);
      tx0_data  = 8'($urandom);
    end else if (!tx0_valid) begin
      tx0_valid = req_always | ($urandom_range(0, 3) == 0);
      if (tx0_valid) tx0_data = 8'($urandom);
    end
    if (tx1_done) begin
      tx1_valid = req_always | ($urandom_range(0, 1) == 1);
      tx1_data  = 8'($urandom);
    end else if (!tx1_valid) begin
      tx1_valid = req_always | ($urandom_range(0, 3) == 0);
      if (tx1_valid) tx1_data = 8'($urandom);
    end

    rx_ready = !rx_ready_off && ($urandom_range(0, 2) == 0);
    rx_next  = m_rx_valid && !rx_ready;

    wb_ack_i = 1'b0;
    wb_dat_i = $urandom;
    if (cyc_s && !old_drop) begin
      if (!(slave_dead || (stall_wr && cur_op == OP_WR)) && wait_left == 0) begin
        wb_ack_i = 1'b1;
        e_drop   = 1;
        next_op  = OP_POLL;
        exp_low  = GAP + 1;
        txn_cnt++;
        case (cur_op)
          OP_POLL: begin
            if (force_ucr_en) begin
              ucr = force_ucr;
            end else begin
              ucr    = $urandom;
              ucr[0] = ($urandom_range(0, 1) == 1);
              ucr[1] = ($urandom_range(0, 3) == 0);
              ucr[4] = ($urandom_range(0, 3) == 0);
            end
            wb_dat_i = ucr;
            e_rxerr  = ucr[1];
            if (ucr[0] && !m_rx_valid) begin
              next_op = OP_RD;
            end else if (!ucr[4] && (tx0_valid || tx1_valid)) begin
              next_op = OP_WR;
              if (tx0_valid && tx1_valid) grant = 1 - last_grant;
              else grant = tx1_valid ? 1 : 0;
              wr_byte = (grant == 1) ? tx1_data : tx0_data;
            end
            if (next_op != OP_POLL) exp_low = 1;
            $display("txn %0d POLL ucr=%08h next=%s", txn_cnt, ucr, op_name(next_op));
          end
          OP_RD: begin
            b         = 8'($urandom);
            junk      = $urandom;
            wb_dat_i  = {junk[31:8], b};
            rx_next   = 1'b1;
            m_rx_byte = b;
            $display("txn %0d READ byte=%02h", txn_cnt, b);
          end
          default: begin
            if (grant == 1) e_tx1r = 1;
            else e_tx0r = 1;
            last_grant = grant;
            $display("txn %0d WRITE tx%0d byte=%02h", txn_cnt, grant, wr_byte);
          end
        endcase
      end else begin
        if (wait_left > 0) wait_left--;
        if (hi_cnt == TMO) begin
          e_drop   = 1;
          e_buserr = 1;
          next_op  = OP_POLL;
          exp_low  = GAP + 1;
          txn_cnt++;
          $display("txn %0d %s timeout", txn_cnt, op_name(cur_op));
        end
      end
    end
    m_rx_valid = rx_next;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    bit found;
    model_init();
    do_reset();

    run(500);                                  // fully random traffic

    force_ucr_en = 1; force_ucr = 32'h0;       // both requesters, idle UART
    req_always = 1;
    run(200);
    req_always = 0;

    force_ucr = 32'h01; rx_ready_off = 1;      // byte held, no further reads
    run(150);
    rx_ready_off = 0;

    force_ucr = 32'h12; req_always = 1;        // rx error with tx busy
    run(100);
    req_always = 0;
    force_ucr_en = 0;
    run(100);

    slave_dead = 1;                            // no acks at all
    run(60);
    slave_dead = 0;
    run(100);

    force_ucr_en = 1; force_ucr = 32'h0;       // reset in the middle of a write
    req_always = 1; stall_wr = 1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (prev_cyc && cur_op == OP_WR && hi_cnt >= 2) found = 1;
    end
    check_eq("wr_reached", found, 1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) begin
      @(negedge clk);
      check_eq("midrst_no_ready", {tx1_ready, tx0_ready}, 0);
    end
    stall_wr = 0; req_always = 0; force_ucr_en = 0;
    wb_ack_i = 1'b0;
    reset = 1'b1;
    model_init();
    run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
